// File: rtl/dsm_feeder.sv
// Sample scheduler/conditioner ahead of the dsm modulator: FIFO, one pop per OSR clocks,
// linear interpolation at clk rate, soft mute ramp and symmetric clamp on the output.
module dsm_feeder #(
  parameter int PCM_QUANT    = 16,
  parameter int OSR_LOG2     = 6,
  parameter int FIFO_LOG2    = 2,
  parameter int RAMP_LOG2    = 8,
  parameter int UNDERRUN_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [PCM_QUANT-1:0]   s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [PCM_QUANT-1:0]   pcm,
  output logic                   tick,
  output logic                   underrun,
  output logic [1:0]             state,
  output logic [FIFO_LOG2:0]     fifo_level
);

  localparam int W     = PCM_QUANT;
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int G     = 1 << RAMP_LOG2;
  localparam int AW    = W + OSR_LOG2 + 1;
  localparam int PW    = W + RAMP_LOG2 + 2;
  localparam int CW    = $clog2(UNDERRUN_MAX + 1);

  localparam logic signed [PW-1:0] PMAX = PW'(2 ** (W - 1) - 1);
  localparam logic signed [PW-1:0] PMIN = -PMAX;

  typedef enum logic [1:0] {
    MUTE      = 2'd0,
    RAMP_UP   = 2'd1,
    PLAY      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t                st;
  logic [OSR_LOG2-1:0]   phase;
  logic [W-1:0]          mem [DEPTH];
  logic [FIFO_LOG2-1:0]  rd_ptr;
  logic [FIFO_LOG2-1:0]  wr_ptr;
  logic [FIFO_LOG2:0]    level;
  logic signed [AW-1:0]  acc;
  logic signed [W:0]     delta;
  logic signed [W-1:0]   target;
  logic [RAMP_LOG2:0]    gain;
  logic [CW-1:0]         ucnt;

  logic                  active;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  starve;
  logic [CW-1:0]         ucnt_nxt;
  logic signed [W-1:0]   head;
  logic signed [W:0]     interp;
  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  y;
  logic [W-1:0]          pcm_nxt;

  assign state      = st;
  assign fifo_level = level;
  assign tick       = &phase;
  assign active     = (st != MUTE);
  assign empty      = (level == '0);
  assign s_ready    = !rst && (level < (FIFO_LOG2 + 1)'(DEPTH));
  assign push       = s_valid && s_ready;
  assign pop        = tick && active && !empty;
  assign head       = $signed(mem[rd_ptr]);
  assign starve     = (ucnt_nxt == CW'(UNDERRUN_MAX));

  // acc's low OSR_LOG2 bits are the sub-sample fraction; dropping them is the floor.
  assign interp = acc[AW-1:OSR_LOG2];
  assign prod   = PW'(interp) * PW'($signed({1'b0, gain}));
  assign y      = prod >>> RAMP_LOG2;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    ucnt_nxt = ucnt;
    if (tick && active) begin
      if (!empty)
        ucnt_nxt = '0;
      else if (ucnt != CW'(UNDERRUN_MAX))
        ucnt_nxt = ucnt + 1'b1;
    end
    pcm_nxt = y[W-1:0];
    if (y > PMAX)
      pcm_nxt = PMAX[W-1:0];
    else if (y < PMIN)
      pcm_nxt = PMIN[W-1:0];
  end

  // NOTE: FIFO storage carries no reset; the pointers and level alone define what is valid.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= s_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= MUTE;
      phase    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      acc      <= '0;
      delta    <= '0;
      target   <= '0;
      gain     <= '0;
      ucnt     <= '0;
      pcm      <= '0;
      underrun <= 1'b0;
    end else begin
      phase    <= phase + 1'b1;
      pcm      <= pcm_nxt;
      ucnt     <= ucnt_nxt;
      underrun <= tick && empty && (st == RAMP_UP || st == PLAY);

      if (active)
        acc <= acc + AW'(delta);

      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        level <= level + 1'b1;
      else if (pop && !push)
        level <= level - 1'b1;

      if (tick && active) begin
        if (pop) begin
          delta  <= (W + 1)'(head) - (W + 1)'(target);
          target <= head;
        end else begin
          delta  <= '0;
        end
      end

      if (tick) begin
        case (st)
          MUTE: begin
            if (enable && !empty)
              st <= RAMP_UP;
          end
          RAMP_UP: begin
            if (!enable || starve) begin
              st <= RAMP_DOWN;
            end else begin
              gain <= gain + 1'b1;
              if (gain == (RAMP_LOG2 + 1)'(G - 1))
                st <= PLAY;
            end
          end
          PLAY: begin
            if (!enable || starve)
              st <= RAMP_DOWN;
          end
          RAMP_DOWN: begin
            if (gain <= (RAMP_LOG2 + 1)'(1)) begin
              // Reaching silence discards everything queued so a re-arm starts from zero.
              st     <= MUTE;
              gain   <= '0;
              rd_ptr <= '0;
              wr_ptr <= '0;
              level  <= '0;
              acc    <= '0;
              delta  <= '0;
              target <= '0;
              ucnt   <= '0;
            end else begin
              gain <= gain - 1'b1;
            end
          end
          default: st <= MUTE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsm_feeder.sv
// Self-checking bench for dsm_feeder: randomized pushes compared every clk against a
// span-based arithmetic model (queue FIFO, linear ramp between targets, gain, clamp).
module tb_dsm_feeder;

  localparam int W   = 16;
  localparam int OSR = 64;
  localparam int G   = 256;
  localparam int LIM = 32767;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic [W-1:0] s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] pcm;
  logic         tick;
  logic         underrun;
  logic [1:0]   state;
  logic [2:0]   fifo_level;

  dsm_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .pcm        (pcm),
    .tick       (tick),
    .underrun   (underrun),
    .state      (state),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int floor_div(input int a, input int d);
    int r;
    r = a / d;
    if ((a % d != 0) && (a < 0))
      r = r - 1;
    return r;
  endfunction

  // Reference model: the current span runs from m_prev to m_tgt; m_k clks have elapsed in it.
  int q[$];
  int m_phase = 0;
  int m_state = 0;
  int m_gain  = 0;
  int m_prev  = 0;
  int m_tgt   = 0;
  int m_k     = 0;
  int m_cnt   = 0;
  int m_pcm   = 0;
  int m_under = 0;

  always @(posedge clk) begin : model
    int  lvl, interp, yv;
    bit  tk, do_push, flushed;
    if (rst) begin
      q.delete();
      m_phase = 0; m_state = 0; m_gain = 0; m_prev = 0; m_tgt = 0;
      m_k = 0; m_cnt = 0; m_pcm = 0; m_under = 0;
    end else begin
      tk      = (m_phase == OSR - 1);
      lvl     = q.size();
      do_push = s_valid && (lvl < 4);
      flushed = 1'b0;
      interp  = floor_div(m_prev * OSR + m_k * (m_tgt - m_prev), OSR);
      yv      = floor_div(interp * m_gain, G);
      m_pcm   = (yv > LIM) ? LIM : (yv < -LIM) ? -LIM : yv;
      m_under = 0;
      if (m_state != 0) begin
        if (tk) begin
          m_prev = m_tgt;
          m_k    = 0;
          if (lvl > 0) begin
            m_tgt = q.pop_front();
            m_cnt = 0;
          end else begin
            m_cnt   = (m_cnt < 4) ? m_cnt + 1 : 4;
            m_under = (m_state == 1 || m_state == 2) ? 1 : 0;
          end
        end else begin
          m_k++;
        end
      end
      if (tk) begin
        case (m_state)
          0: if (enable && lvl > 0) m_state = 1;
          1: begin
            if (!enable || m_cnt == 4) m_state = 3;
            else begin
              m_gain++;
              if (m_gain == G) m_state = 2;
            end
          end
          2: if (!enable || m_cnt == 4) m_state = 3;
          default: begin
            if (m_gain <= 1) begin
              m_state = 0; m_gain = 0; q.delete();
              m_prev = 0; m_tgt = 0; m_k = 0; m_cnt = 0;
              flushed = 1'b1;
            end else begin
              m_gain--;
            end
          end
        endcase
      end
      if (do_push && !flushed)
        q.push_back(int'($signed(s_data)));
      m_phase = (m_phase + 1) % OSR;
    end
  end

  always @(negedge clk) begin
    check("pcm",      int'($signed(pcm)), m_pcm);
    check("state",    int'(state), m_state);
    check("level",    int'(fifo_level), q.size());
    check("tick",     int'(tick), (m_phase == OSR - 1) ? 1 : 0);
    check("underrun", int'(underrun), m_under);
    check("s_ready",  int'(s_ready), (!rst && q.size() < 4) ? 1 : 0);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_state(input int st, input int budget, input string tag);
    int n = 0;
    while (int'(state) != st && n < budget) begin
      cyc();
      n++;
    end
    check(tag, int'(state), st);
  endtask

  task automatic push_one(input int v);
    int n = 0;
    s_data  = W'(v);
    s_valid = 1'b1;
    while (!s_ready && n < 500) begin
      cyc();
      n++;
    end
    cyc();
    s_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_sample();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 16'h8000;
    if (sel == 1) return 16'h7fff;
    return W'($urandom);
  endfunction

  initial begin : stim
    int pulses;
    int dir[4];
    dir[0] = 0; dir[1] = 6400; dir[2] = -32768; dir[3] = 32767;

    repeat (3) cyc();
    check("reset_state", int'(state), 0);
    check("reset_pcm", int'($signed(pcm)), 0);
    check("reset_ready", int'(s_ready), 0);
    rst = 1'b0;

    enable  = 1'b1;
    s_data  = 16'h4000;
    s_valid = 1'b1;
    wait_state(1, 200, "arm_ramp_up");
    wait_state(2, 20000, "reach_play");
    repeat (200) cyc();

    s_valid = 1'b0;
    foreach (dir[i]) push_one(dir[i]);
    repeat (300) cyc();

    for (int i = 0; i < 4000; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = rand_sample();
      cyc();
    end
    check("still_play", int'(state), 2);

    s_valid = 1'b0;
    pulses  = 0;
    for (int i = 0; i < 2000 && int'(state) != 3; i++) begin
      cyc();
      if (underrun) pulses++;
    end
    check("underrun_pulses", pulses, 4);
    wait_state(0, 20000, "reach_mute");
    check("mute_level", int'(fifo_level), 0);

    enable  = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data = rand_sample();
      cyc();
    end
    check("full_level", int'(fifo_level), 4);
    check("full_ready", int'(s_ready), 0);
    enable = 1'b1;
    for (int i = 0; i < 30 * OSR; i++) begin
      s_data = rand_sample();
      cyc();
    end
    check("mid_ramp_state", int'(state), 1);

    rst = 1'b1;
    cyc();
    check("rst_state", int'(state), 0);
    check("rst_pcm", int'($signed(pcm)), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_tick", int'(tick), 0);
    rst = 1'b0;

    wait_state(1, 200, "rearm");
    for (int i = 0; i < 20 * OSR; i++) begin
      s_valid = ($urandom_range(0, 1) != 0);
      s_data  = rand_sample();
      cyc();
    end
    enable = 1'b0;
    wait_state(3, 200, "abort_ramp");
    wait_state(0, 3000, "short_ramp_down");
    repeat (10) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
